// File: rtl/pong_match_if.sv
// Match-controller bus: frame/ball/button inputs and the match status outputs.
// Pure wiring, no latency of its own.
// No backpressure; every signal is a level or a single-cycle pulse.
interface pong_match_if;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic       p1_srv;
  logic       p2_srv;
  logic       p1_hit;
  logic       p2_hit;
  logic [1:0] state;
  logic [1:0] serve_side;
  logic       ball_launch;
  logic       launch_dir;
  logic       ball_reset;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;
  logic       beep_lo;
  logic       beep_hi;

  // Stimulus side: drives buttons, collisions and ball position.
  modport master (
    output frame_tick, ball_x, p1_srv, p2_srv, p1_hit, p2_hit,
    input  state, serve_side, ball_launch, launch_dir, ball_reset,
    input  score_p1, score_p2, winner, beep_lo, beep_hi
  );

  // Controller side.
  modport slave (
    input  frame_tick, ball_x, p1_srv, p2_srv, p1_hit, p2_hit,
    output state, serve_side, ball_launch, launch_dir, ball_reset,
    output score_p1, score_p2, winner, beep_lo, beep_hi
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve, launch, miss scoring, point delay, match end, beeps.
// Latency: one cycle from a sampled input edge to every registered output.
// No backpressure; inputs are sampled every cycle and never stalled.
module pong_match_ctrl #(
  parameter int         WIN_SCORE    = 11,      // 1..15
  parameter logic [9:0] LEFT_LIMIT   = 10'd8,
  parameter logic [9:0] RIGHT_LIMIT  = 10'd632,
  parameter logic [9:0] WRAP_MIN     = 10'd960,
  parameter int         POINT_FRAMES = 60,      // 1..255
  parameter int         BEEP_FRAMES  = 6        // 1..63
) (
  input  logic         clk,
  input  logic         rst_n,
  pong_match_if.slave  bus
);

  typedef enum logic [1:0] {
    S_SERVE = 2'b00,
    S_PLAY  = 2'b01,
    S_POINT = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [3:0] WIN_Q     = 4'(WIN_SCORE);
  localparam logic [7:0] PT_LOAD   = 8'(POINT_FRAMES);
  localparam logic [5:0] BEEP_LOAD = 6'(BEEP_FRAMES);

  state_t     st;
  logic [1:0] serve_side;
  logic       ball_launch;
  logic       launch_dir;
  logic       ball_reset;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;
  logic       beep_lo;
  logic       beep_hi;
  logic [7:0] pt_cnt;
  logic [5:0] beep_cnt;
  logic       next_p1;   // 1 = p1 serves after the current point

  // Edge-detect history; resets low so an input held across reset is an edge.
  logic p1_srv_q, p2_srv_q, p1_hit_q, p2_hit_q;

  logic       p1_srv_re, p2_srv_re, p1_hit_re, p2_hit_re;
  logic       left_miss, right_miss;
  logic [3:0] p1_inc, p2_inc;
  logic       beep_start;
  logic [1:0] beep_set;  // [0] = lo, [1] = hi

  assign p1_srv_re = bus.p1_srv & ~p1_srv_q;
  assign p2_srv_re = bus.p2_srv & ~p2_srv_q;
  assign p1_hit_re = bus.p1_hit & ~p1_hit_q;
  assign p2_hit_re = bus.p2_hit & ~p2_hit_q;

  // Values at or above WRAP_MIN are the ball having underflowed past 0.
  assign left_miss  = bus.frame_tick &
                      ((bus.ball_x < LEFT_LIMIT) || (bus.ball_x >= WRAP_MIN));
  assign right_miss = bus.frame_tick &
                      (bus.ball_x > RIGHT_LIMIT) && (bus.ball_x < WRAP_MIN);

  assign p1_inc = (score_p1 == 4'hf) ? 4'hf : score_p1 + 4'd1;
  assign p2_inc = (score_p2 == 4'hf) ? 4'hf : score_p2 + 4'd1;

  // Beep request for this cycle: a miss beeps both tones and masks any hit.
  always_comb begin
    beep_start = 1'b0;
    beep_set   = 2'b00;
    if (st == S_PLAY) begin
      if (left_miss || right_miss) begin
        beep_start = 1'b1;
        beep_set   = 2'b11;
      end else if (p1_hit_re) begin
        beep_start = 1'b1;
        beep_set   = 2'b01;
      end else if (p2_hit_re) begin
        beep_start = 1'b1;
        beep_set   = 2'b10;
      end
    end
  end

  // Match state machine, scores, serve selection and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_SERVE;
      serve_side  <= 2'b01;
      ball_launch <= 1'b0;
      launch_dir  <= 1'b0;
      ball_reset  <= 1'b0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      winner      <= 2'b00;
      pt_cnt      <= 8'd0;
      next_p1     <= 1'b0;
      p1_srv_q    <= 1'b0;
      p2_srv_q    <= 1'b0;
      p1_hit_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
    end else begin
      p1_srv_q    <= bus.p1_srv;
      p2_srv_q    <= bus.p2_srv;
      p1_hit_q    <= bus.p1_hit;
      p2_hit_q    <= bus.p2_hit;
      ball_launch <= 1'b0;
      ball_reset  <= 1'b0;
      case (st)
        S_SERVE: begin
          if (p1_srv_re && serve_side[1]) begin
            ball_launch <= 1'b1;
            launch_dir  <= 1'b1;
            serve_side  <= 2'b00;
            st          <= S_PLAY;
          end else if (p2_srv_re && serve_side[0]) begin
            ball_launch <= 1'b1;
            launch_dir  <= 1'b0;
            serve_side  <= 2'b00;
            st          <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (left_miss) begin
            ball_reset <= 1'b1;
            pt_cnt     <= PT_LOAD;
            next_p1    <= 1'b1;
            score_p2   <= p2_inc;
            if (p2_inc == WIN_Q) begin
              winner <= 2'b10;
              st     <= S_OVER;
            end else begin
              st     <= S_POINT;
            end
          end else if (right_miss) begin
            ball_reset <= 1'b1;
            pt_cnt     <= PT_LOAD;
            next_p1    <= 1'b0;
            score_p1   <= p1_inc;
            if (p1_inc == WIN_Q) begin
              winner <= 2'b01;
              st     <= S_OVER;
            end else begin
              st     <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (bus.frame_tick) begin
            if (pt_cnt <= 8'd1) begin
              pt_cnt     <= 8'd0;
              serve_side <= next_p1 ? 2'b10 : 2'b01;
              st         <= S_SERVE;
            end else begin
              pt_cnt <= pt_cnt - 8'd1;
            end
          end
        end
        default: begin
          if (p1_srv_re || p2_srv_re) begin
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            winner     <= 2'b00;
            serve_side <= 2'b01;
            ball_reset <= 1'b1;
            st         <= S_SERVE;
          end
        end
      endcase
    end
  end

  // Beep timer: a new request reloads and replaces; otherwise count frames down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt <= 6'd0;
      beep_lo  <= 1'b0;
      beep_hi  <= 1'b0;
    end else if (beep_start) begin
      beep_cnt <= BEEP_LOAD;
      beep_lo  <= beep_set[0];
      beep_hi  <= beep_set[1];
    end else if (bus.frame_tick && (beep_cnt != 6'd0)) begin
      beep_cnt <= beep_cnt - 6'd1;
      if (beep_cnt == 6'd1) begin
        beep_lo <= 1'b0;
        beep_hi <= 1'b0;
      end
    end
  end

  assign bus.state       = st;
  assign bus.serve_side  = serve_side;
  assign bus.ball_launch = ball_launch;
  assign bus.launch_dir  = launch_dir;
  assign bus.ball_reset  = ball_reset;
  assign bus.score_p1    = score_p1;
  assign bus.score_p2    = score_p2;
  assign bus.winner      = winner;
  assign bus.beep_lo     = beep_lo;
  assign bus.beep_hi     = beep_hi;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters.
// Each frame is two clocks: one with frame_tick high, one low.
// Inputs driven and outputs sampled 1 ns after the rising edge.
module tb_pong_match_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pong_match_if bus ();

  pong_match_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ftick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    cyc();
  endtask

  task automatic nticks(input int n);
    for (int i = 0; i < n; i++) ftick();
  endtask

  task automatic srv2();
    bus.p2_srv = 1'b1;
    cyc();
    bus.p2_srv = 1'b0;
    cyc();
  endtask

  // p2 serves, ball exits right on a frame, then the point delay elapses.
  task automatic score_right();
    srv2();
    bus.ball_x = 10'd640;
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    bus.ball_x = 10'd320;
    cyc();
    nticks(60);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.ball_x     = 10'd320;
    bus.p1_srv     = 1'b0;
    bus.p2_srv     = 1'b0;
    bus.p1_hit     = 1'b0;
    bus.p2_hit     = 1'b0;

    // Reset values
    #23;
    chk("rst_state", bus.state, 2'b00);
    chk("rst_side", bus.serve_side, 2'b01);
    chk("rst_dir", bus.launch_dir, 1'b0);
    chk("rst_pulses", {bus.ball_launch, bus.ball_reset}, 2'b00);
    chk("rst_beeps", {bus.beep_lo, bus.beep_hi}, 2'b00);
    chk("rst_scores", {bus.score_p1, bus.score_p2}, 8'h00);
    chk("rst_winner", bus.winner, 2'b00);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Wrong side serve ignored, right side serve launches leftward
    bus.p1_srv = 1'b1;
    cyc();
    chk("p1_srv_ignored_state", bus.state, 2'b00);
    chk("p1_srv_ignored_launch", bus.ball_launch, 1'b0);
    bus.p1_srv = 1'b0;
    cyc();
    bus.p2_srv = 1'b1;
    cyc();
    chk("launch_pulse", bus.ball_launch, 1'b1);
    chk("launch_dir_left", bus.launch_dir, 1'b0);
    chk("launch_state", bus.state, 2'b01);
    chk("launch_side", bus.serve_side, 2'b00);
    bus.p2_srv = 1'b0;
    cyc();
    chk("launch_one_cycle", bus.ball_launch, 1'b0);

    // Left miss through wrap region
    bus.ball_x = 10'd1020;
    bus.frame_tick = 1'b1;
    cyc();
    chk("lmiss_score_p2", bus.score_p2, 4'd1);
    chk("lmiss_ball_reset", bus.ball_reset, 1'b1);
    chk("lmiss_beeps", {bus.beep_lo, bus.beep_hi}, 2'b11);
    chk("lmiss_state", bus.state, 2'b10);
    bus.frame_tick = 1'b0;
    bus.ball_x = 10'd320;
    cyc();
    chk("lmiss_reset_one_cycle", bus.ball_reset, 1'b0);
    nticks(5);
    chk("beep_on_after5", {bus.beep_lo, bus.beep_hi}, 2'b11);
    ftick();
    chk("beep_off_after6", {bus.beep_lo, bus.beep_hi}, 2'b00);
    nticks(53);
    chk("point_after59", bus.state, 2'b10);
    ftick();
    chk("point_done_state", bus.state, 2'b00);
    chk("point_done_side", bus.serve_side, 2'b10);

    // p1 serves rightward
    bus.p1_srv = 1'b1;
    cyc();
    chk("p1_launch_dir", bus.launch_dir, 1'b1);
    chk("p1_launch_state", bus.state, 2'b01);
    bus.p1_srv = 1'b0;
    cyc();

    // Coincident hits: p1 wins, held level does not retrigger
    bus.p1_hit = 1'b1;
    bus.p2_hit = 1'b1;
    cyc();
    chk("dual_hit_beeps", {bus.beep_lo, bus.beep_hi}, 2'b10);
    bus.p2_hit = 1'b0;
    nticks(5);
    chk("hit_beep_on_after5", bus.beep_lo, 1'b1);
    ftick();
    chk("hit_beep_off_after6", bus.beep_lo, 1'b0);
    nticks(2);
    chk("held_hit_no_retrigger", {bus.beep_lo, bus.beep_hi}, 2'b00);
    bus.p1_hit = 1'b0;
    cyc();

    // Miss position without frame_tick scores nothing
    bus.ball_x = 10'd640;
    cyc();
    cyc();
    chk("no_tick_no_score", bus.score_p1, 4'd0);
    chk("no_tick_state", bus.state, 2'b01);

    // Miss and p2 hit edge on the same frame: point wins, both beeps
    bus.p2_hit = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    chk("miss_hit_score_p1", bus.score_p1, 4'd1);
    chk("miss_hit_beeps", {bus.beep_lo, bus.beep_hi}, 2'b11);
    chk("miss_hit_state", bus.state, 2'b10);
    bus.p2_hit = 1'b0;
    bus.frame_tick = 1'b0;
    bus.ball_x = 10'd320;
    cyc();
    nticks(60);
    chk("rmiss_next_side", bus.serve_side, 2'b01);

    // Run p1 up to 10, then the winning point
    for (int i = 0; i < 9; i++) score_right();
    chk("p1_at_10", bus.score_p1, 4'd10);
    chk("p1_at_10_state", bus.state, 2'b00);
    srv2();
    bus.ball_x = 10'd640;
    bus.frame_tick = 1'b1;
    cyc();
    chk("win_score", bus.score_p1, 4'd11);
    chk("win_state", bus.state, 2'b11);
    chk("win_winner", bus.winner, 2'b01);
    bus.frame_tick = 1'b0;
    bus.ball_x = 10'd320;
    cyc();
    nticks(3);
    chk("over_held", {bus.state, bus.winner, bus.score_p1, bus.score_p2}, 12'hd_b1);
    bus.p2_srv = 1'b1;
    cyc();
    chk("restart_scores", {bus.score_p1, bus.score_p2}, 8'h00);
    chk("restart_state", bus.state, 2'b00);
    chk("restart_side", bus.serve_side, 2'b01);
    chk("restart_winner", bus.winner, 2'b00);
    chk("restart_ball_reset", bus.ball_reset, 1'b1);
    bus.p2_srv = 1'b0;
    cyc();

    // Limit boundaries
    srv2();
    bus.ball_x = 10'd8;
    ftick();
    chk("left_limit_edge", bus.state, 2'b01);
    bus.ball_x = 10'd632;
    ftick();
    chk("right_limit_edge", bus.state, 2'b01);
    bus.ball_x = 10'd959;
    bus.frame_tick = 1'b1;
    cyc();
    chk("below_wrap_right_miss", bus.score_p1, 4'd1);
    chk("below_wrap_state", bus.state, 2'b10);
    bus.frame_tick = 1'b0;
    bus.ball_x = 10'd320;
    cyc();
    nticks(2);

    // Asynchronous reset during POINT
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", bus.state, 2'b00);
    chk("async_rst_side", bus.serve_side, 2'b01);
    chk("async_rst_scores", {bus.score_p1, bus.score_p2}, 8'h00);
    chk("async_rst_beeps", {bus.beep_lo, bus.beep_hi}, 2'b00);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Wrap minimum is a left miss
    srv2();
    bus.ball_x = 10'd960;
    bus.frame_tick = 1'b1;
    cyc();
    chk("wrap_min_left_miss", bus.score_p2, 4'd1);
    bus.frame_tick = 1'b0;
    bus.ball_x = 10'd320;
    cyc();
    nticks(60);
    chk("wrap_next_side", bus.serve_side, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
